instruction_memory_ctrl: RTL and testbench
==========================================

Name: instruction_memory_ctrl

Overview:
- Block-level instruction memory sitting directly downstream of the instruction cache.
- Services cache-miss refills: accepts a block address plus a read request, holds busywait for a fixed latency, then returns one 128-bit block (four 32-bit instructions).
- Contains a 1024-byte byte-addressed program store, loaded through a byte-wide program port by the bench/loader before execution.

Parameters:
- READ_LATENCY, 4, cycles busywait stays high per fetch; legal range 1..63.
- BLOCK_ADDR_W, 6, block address width; store size = 2^BLOCK_ADDR_W x 16 bytes.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  fetch request from the cache, level-sensitive.
- address  in  BLOCK_ADDR_W  block address {tag,index} of the requested block.
- readinst  out  128  fetched block; byte k of the block is readinst[8k+7:8k].
- busywait  out  1  high while a fetch is in progress.
- prog_we  in  1  program-store byte write enable.
- prog_addr  in  BLOCK_ADDR_W+4  program-store byte address.
- prog_data  in  8  program-store write data.

Behaviour:
- Reset (async, immediate): busywait=0, readinst=0, state=IDLE, counter=0, latched address=0. The program store is NOT cleared.
- Reset mid-fetch aborts the fetch. No response is produced, and the state is IDLE on the first edge after reset deasserts.
- States: IDLE, FETCH, DONE.
- IDLE:
  - At a posedge with read=1: latch address, load counter=READ_LATENCY-1, set busywait=1, go to FETCH.
  - With read=0: stay in IDLE, outputs hold.
- FETCH:
  - Each posedge with counter!=0: decrement the counter.
  - At the posedge with counter==0: load readinst from store bytes {addr_lat,4'h0}..{addr_lat,4'hF} (little-endian), set busywait=0, go to DONE.
  - Changes to read or address during FETCH are ignored; only the latched address is used.
- Timing: if the request edge is E0, busywait is high for exactly READ_LATENCY cycles and falls at edge E_L (L=READ_LATENCY), with readinst valid at the same edge.
- DONE:
  - Exactly one cycle. read is ignored at edge E_L+1, which covers the cache dropping read on that same edge.
  - Return to IDLE. The earliest new request is accepted at edge E_L+2.
- readinst holds its last fetched value until the next fetch completes or a reset occurs.
- A repeated request to the same address performs a full fetch; there is no memoisation.
- Store snapshot: store bytes are sampled at the completion edge. A prog_we write to the fetched block during FETCH is visible only if it happened at or before that edge.
- prog_we writes the store at posedge in any state; the loader is required to write only while busywait=0.
- Word mapping: readinst[31:0] holds bytes 0..3 (offset 00) and readinst[127:96] holds bytes 12..15 (offset 11), matching the cache offset decode.
- Counter width is 6 bits; no wrap occurs within the legal READ_LATENCY range.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum (IDLE/FETCH/DONE)
  - BLOCK_BYTES=16
  - WORD_W=32
  - BLOCK_W=128
  - default latency constants shared with the data-memory controller
- One natural sub-module, prog_store: 1024x8 array with a synchronous byte write port and a combinational 16-byte block read port.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> busywait=0 and readinst=0 immediately; no activity with read=0 for 10 cycles.
- Basic fetch: load bytes 0x00..0x0F with values 0x00..0x0F, request address=0 at E0 -> busywait high for 4 cycles, falls at E4 with readinst=128'h0F0E0D0C_0B0A0908_07060504_03020100.
- Top block and address hold: load the block at address 6'h3F with 0xA0..0xAF, request address=6'h3F, then change address to 0 during FETCH -> readinst[31:0]=32'hA3A2A1A0 and readinst[127:96]=32'hAFAEADAC.
- Cache-style read hold: keep read=1 through E4 and E5, then drop it -> no second fetch starts at E5; busywait stays 0 and readinst is unchanged.
- Back-to-back requests: re-assert read at E6 with address=1 -> busywait rises at E6 and falls at E10 with the block-1 data.
- Reset mid-fetch: request at E0, assert reset at E2 -> busywait=0 and readinst=0 immediately; a fresh request after release returns the correct block with full latency. Repeat the whole suite with READ_LATENCY=1 (busywait high exactly one cycle).

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Types and constants shared by the instruction- and data-memory controllers.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } mem_state_e;

  localparam int BLOCK_BYTES = 16;
  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 4 * WORD_W;
  localparam int CNT_W       = 6;

  localparam int IMEM_READ_LATENCY = 4;
  localparam int DMEM_READ_LATENCY = 5;

  // Bit position of byte lane k inside a block (little-endian lanes).
  function automatic logic [6:0] byte_lane_lsb(input logic [3:0] k);
    return {k, 3'b000};
  endfunction

endpackage

// File: rtl/instruction_memory_ctrl_prog_store.sv
// Byte-addressed program store: synchronous byte write, combinational block read.
module prog_store
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W+3:0]  waddr,
  input  logic [7:0]         wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [BLOCK_W-1:0] rblock
);

  localparam int DEPTH = (2 ** ADDR_W) * BLOCK_BYTES;

  logic [7:0] mem_r [DEPTH];

  // Loader write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Gather the sixteen bytes of the addressed block.
  always_comb begin
    rblock = {BLOCK_W{1'b0}};
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      rblock[byte_lane_lsb(4'(k)) +: 8] = mem_r[{raddr, 4'(k)}];
    end
  end

endmodule

// File: rtl/instruction_memory_ctrl.sv
// Instruction memory behind the I-cache: fixed-latency 128-bit block refills.
module instruction_memory_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int READ_LATENCY = IMEM_READ_LATENCY,
  parameter int BLOCK_ADDR_W = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic [BLOCK_ADDR_W-1:0] address,
  output logic [BLOCK_W-1:0]      readinst,
  output logic                    busywait,
  input  logic                    prog_we,
  input  logic [BLOCK_ADDR_W+3:0] prog_addr,
  input  logic [7:0]              prog_data
);

  localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e              state_r, state_next_s;
  logic [CNT_W-1:0]        counter_r, counter_next_s;
  logic [BLOCK_ADDR_W-1:0] addr_lat_r, addr_next_s;
  logic                    busy_next_s;
  logic [BLOCK_W-1:0]      readinst_next_s;
  logic [BLOCK_W-1:0]      store_block_s;
  logic [BLOCK_W-1:0]      block_s;

  prog_store #(.ADDR_W(BLOCK_ADDR_W)) u_store (
    .clock  (clock),
    .we     (prog_we),
    .waddr  (prog_addr),
    .wdata  (prog_data),
    .raddr  (addr_lat_r),
    .rblock (store_block_s)
  );

  // A loader write landing on the completion edge must appear in the returned block.
  always_comb begin
    block_s = store_block_s;
    if (prog_we && (prog_addr[BLOCK_ADDR_W+3:4] == addr_lat_r)) begin
      block_s[byte_lane_lsb(prog_addr[3:0]) +: 8] = prog_data;
    end else begin
      block_s = store_block_s;
    end
  end

  // Next-state, counter and output decode for the fetch sequencer.
  always_comb begin
    state_next_s    = state_r;
    counter_next_s  = counter_r;
    addr_next_s     = addr_lat_r;
    busy_next_s     = busywait;
    readinst_next_s = readinst;
    case (state_r)
      IDLE: begin
        if (read) begin
          addr_next_s    = address;
          counter_next_s = LAT_M1;
          busy_next_s    = 1'b1;
          state_next_s   = FETCH;
        end else begin
          state_next_s   = IDLE;
        end
      end
      FETCH: begin
        if (counter_r != CNT_ZERO) begin
          counter_next_s  = counter_r - CNT_ONE;
        end else begin
          readinst_next_s = block_s;
          busy_next_s     = 1'b0;
          state_next_s    = DONE;
        end
      end
      // One dead cycle so a cache still holding read does not retrigger.
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      counter_r  <= CNT_ZERO;
      addr_lat_r <= {BLOCK_ADDR_W{1'b0}};
      busywait   <= 1'b0;
      readinst   <= {BLOCK_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      counter_r  <= counter_next_s;
      addr_lat_r <= addr_next_s;
      busywait   <= busy_next_s;
      readinst   <= readinst_next_s;
    end
  end

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Randomised and directed bench for instruction_memory_ctrl at latencies 4 and 1.
module tb_instruction_memory_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         read = 1'b0;
  logic [5:0]   address = 6'd0;
  logic         prog_we = 1'b0;
  logic [9:0]   prog_addr = 10'd0;
  logic [7:0]   prog_data = 8'd0;
  logic [127:0] readinst4, readinst1;
  logic         busy4, busy1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  instruction_memory_ctrl #(.READ_LATENCY(4), .BLOCK_ADDR_W(6)) u_dut4 (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readinst(readinst4), .busywait(busy4),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

  instruction_memory_ctrl #(.READ_LATENCY(1), .BLOCK_ADDR_W(6)) u_dut1 (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readinst(readinst1), .busywait(busy1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

  always #5 clock = ~clock;

  // Reference model: a fetch accepted at cycle c ends at c+L; the next accept is allowed at c+L+2.
  logic [7:0]   mem [1024];
  int           lat [2] = '{4, 1};
  bit           m_busy [2];
  int           m_end [2];
  int           m_next_ok [2];
  logic [5:0]   m_addr [2];
  logic [127:0] m_rd [2];
  int           cyc = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_end[d] = 0; m_next_ok[d] = 0; m_addr[d] = 6'd0; m_rd[d] = 128'd0;
    end
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int d = 0; d < 2; d++) begin
          m_busy[d] = 1'b0; m_next_ok[d] = 0; m_rd[d] = 128'd0;
        end
      end else begin
        cyc = cyc + 1;
        if (prog_we) mem[prog_addr] = prog_data;
        for (int d = 0; d < 2; d++) begin
          if (m_busy[d]) begin
            if (cyc == m_end[d]) begin
              for (int k = 0; k < 16; k++) m_rd[d][8*k +: 8] = mem[{m_addr[d], 4'(k)}];
              m_busy[d] = 1'b0;
              m_next_ok[d] = cyc + 2;
            end
          end else if (read && cyc >= m_next_ok[d]) begin
            m_busy[d] = 1'b1;
            m_addr[d] = address;
            m_end[d]  = cyc + lat[d];
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("busy_L4", {127'd0, busy4}, {127'd0, m_busy[0]});
      chk("readinst_L4", readinst4, m_rd[0]);
      chk("busy_L1", {127'd0, busy1}, {127'd0, m_busy[1]});
      chk("readinst_L1", readinst1, m_rd[1]);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  localparam logic [127:0] BLK0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] BLK1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

  logic [127:0] held;

  initial begin
    // Asynchronous reset asserted mid-cycle
    @(posedge clock); @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_busy_L4", {127'd0, busy4}, 128'd0);
    chk("rst_readinst_L4", readinst4, 128'd0);
    chk("rst_busy_L1", {127'd0, busy1}, 128'd0);
    chk("rst_readinst_L1", readinst1, 128'd0);
    cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("idle_busy_L4", {127'd0, busy4}, 128'd0);

    // Program load: blocks 0/1 = 0x00..0x1F, block 3F = 0xA0..0xAF, rest random
    for (int i = 0; i < 1024; i++) begin
      prog_we   = 1'b1;
      prog_addr = 10'(i);
      if (i < 32)        prog_data = 8'(i);
      else if (i >= 1008) prog_data = 8'(8'hA0 + (i - 1008));
      else               prog_data = 8'($urandom);
      tick();
    end
    prog_we = 1'b0;
    tick();

    // Basic fetch with read held through E5, then back-to-back request at E6
    read = 1'b1; address = 6'd0;
    tick();                                         // E0
    chk("E0_busy_L4", {127'd0, busy4}, 128'd1);
    chk("E0_busy_L1", {127'd0, busy1}, 128'd1);
    tick();                                         // E1
    chk("E1_busy_L1", {127'd0, busy1}, 128'd0);
    chk("E1_readinst_L1", readinst1, BLK0);
    tick(); tick();                                 // E3
    chk("E3_busy_L4", {127'd0, busy4}, 128'd1);
    tick();                                         // E4
    chk("E4_busy_L4", {127'd0, busy4}, 128'd0);
    chk("E4_readinst_L4", readinst4, BLK0);
    tick();                                         // E5
    chk("E5_busy_L4", {127'd0, busy4}, 128'd0);
    chk("E5_readinst_L4", readinst4, BLK0);
    address = 6'd1;
    tick();                                         // E6
    chk("E6_busy_L4", {127'd0, busy4}, 128'd1);
    read = 1'b0;
    tick(); tick(); tick();                         // E9
    chk("E9_busy_L4", {127'd0, busy4}, 128'd1);
    tick();                                         // E10
    chk("E10_busy_L4", {127'd0, busy4}, 128'd0);
    chk("E10_readinst_L4", readinst4, BLK1);
    repeat (3) tick();

    // Top block; address changes during FETCH, read held through E5 then dropped
    read = 1'b1; address = 6'h3F;
    tick();                                         // E0
    address = 6'd0;
    repeat (4) tick();                              // E4
    chk("top_lo_word", {96'd0, readinst4[31:0]}, {96'd0, 32'hA3A2A1A0});
    chk("top_hi_word", {96'd0, readinst4[127:96]}, {96'd0, 32'hAFAEADAC});
    held = readinst4;
    tick();                                         // E5
    read = 1'b0;
    repeat (3) begin
      tick();
      chk("hold_busy_L4", {127'd0, busy4}, 128'd0);
      chk("hold_readinst_L4", readinst4, held);
    end

    // Reset mid-fetch, then a clean fetch with full latency
    read = 1'b1; address = 6'd1;
    tick();                                         // E0
    read = 1'b0;
    tick();                                         // E1
    @(posedge clock); #2 reset = 1'b1;              // just after E2
    #1;
    chk("abort_busy_L4", {127'd0, busy4}, 128'd0);
    chk("abort_readinst_L4", readinst4, 128'd0);
    tick();
    reset = 1'b0;
    read = 1'b1; address = 6'd0;
    tick();                                         // E0
    read = 1'b0;
    repeat (3) tick();
    chk("refetch_busy_L4", {127'd0, busy4}, 128'd1);
    tick();
    chk("refetch_readinst_L4", readinst4, BLK0);
    repeat (2) tick();

    // Random traffic: requests, loader writes (including during fetches) and resets
    for (int n = 0; n < 600; n++) begin
      read      = 1'($urandom);
      address   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = {4'd0, 6'($urandom)};
      prog_data = 8'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    read = 1'b0; prog_we = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
